// File: rtl/basic_dp_share_pkg.sv
// rtl/basic_dp_share_pkg.sv - shared types and constants for the datapath share controller
package basic_dp_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width of the latency down-counter; covers LAT up to 15.
    localparam int CNT_W = 4;

    // Index width for a requester number; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/basic_dp_share_ctrl_rr_pick.sv
// rtl/basic_dp_share_ctrl_rr_pick.sv - combinational round-robin winner picker
// Ports:
//   req_i  - per-requester request bits
//   ptr_i  - index where the search starts
//   win_o  - index of the first set request at or after ptr_i (wrapping)
//   any_o  - high when at least one request is set
module rr_pick
    import basic_dp_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk ptr, ptr+1, ... wrapping at NREQ; the first set bit wins.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDX_W'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                win_o = idx;
                found = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/basic_dp_share_ctrl.sv
// rtl/basic_dp_share_ctrl.sv - round-robin sequencer sharing one register/OR datapath
// Ports:
//   CLK, ASYNCRESET   - clock, asynchronous active-high reset
//   req, a, b         - per-requester request level and packed operands
//   gnt               - one-hot pulse in the cycle the operands are issued
//   dp_valid, dp_a/b  - issue strobe and operands to the shared datapath
//   dp_result         - datapath OR result
//   resp_valid/_data  - one-hot response held until resp_ready
//   resp_ready        - response accept from the granted requester
//   busy              - controller is not idle
module basic_dp_share_ctrl
    import basic_dp_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2,
    parameter int LAT   = 1
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a,
    input  logic [NREQ*WIDTH-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic                  dp_valid,
    output logic [WIDTH-1:0]      dp_a,
    output logic [WIDTH-1:0]      dp_b,
    input  logic [WIDTH-1:0]      dp_result,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    input  logic                  resp_ready,
    output logic                  busy
);

    localparam int               IDX_W    = idx_w(NREQ);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic [IDX_W-1:0]   win;
    logic               any;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    sel_d   = win;
                    // Operands are latched at selection so the datapath inputs
                    // come straight from registers through ISSUE and WAIT.
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == IDX_W'(i)) begin
                            op_a_d = a[i*WIDTH +: WIDTH];
                            op_b_d = b[i*WIDTH +: WIDTH];
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    res_d   = dp_result;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
        end
    end

    // Every output is a decode of registered state, so reset clears them at once.
    assign gnt        = (state_q == ST_ISSUE) ? (NREQ'(1) << sel_q) : '0;
    assign dp_valid   = (state_q == ST_ISSUE);
    assign dp_a       = op_a_q;
    assign dp_b       = op_b_q;
    assign resp_valid = (state_q == ST_RESP) ? (NREQ'(1) << sel_q) : '0;
    assign resp_data  = res_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
